// File: rtl/satd_stream.sv
// Streaming NxN SATD: per-row Hadamard on load, per-column Hadamard
// with absolute-sum accumulation, rounded result behind valid/ready.
module satd_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int OUT_W = WIDTH + 4 * $clog2(N) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] org_row,
  input  logic [N*WIDTH-1:0] cur_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   satd,
  output logic               busy
);

  localparam int LG  = $clog2(N);
  localparam int D3  = WIDTH + 1 + 2 * LG;
  localparam int SH  = LG - 1;
  localparam int RND = 1 << (LG - 2);

  typedef logic [N-1:0][D3-1:0] vec_t;
  typedef enum logic [1:0] {LOAD, VERT, DONE} state_e;

  // Two's-complement add/sub is sign-agnostic, so packed unsigned is fine
  function automatic vec_t wht(input vec_t x);
    vec_t v;
    logic [D3-1:0] a, b;
    v = x;
    for (int s = 0; s < LG; s++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & (1 << s)) == 0) begin
          a = v[i];
          b = v[i + (1 << s)];
          v[i] = a + b;
          v[i + (1 << s)] = a - b;
        end
      end
    end
    return v;
  endfunction

  state_e state_q, state_d;
  logic [LG-1:0] row_q, row_d;
  logic [LG-1:0] col_q, col_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] satd_q, satd_d;
  logic [D3-1:0] buf_q [N][N];

  logic xfer, last_row, last_col;
  logic signed [WIDTH:0] df;
  logic [D3-1:0] mag;
  vec_t dv, rv, cv, ch;
  logic [OUT_W-1:0] colsum, total;

  assign xfer     = in_valid & in_ready;
  assign last_row = row_q == LG'(N - 1);
  assign last_col = col_q == LG'(N - 1);

  always_comb begin
    df = '0;
    dv = '0;
    for (int i = 0; i < N; i++) begin
      df = $signed({1'b0, org_row[i*WIDTH +: WIDTH]})
         - $signed({1'b0, cur_row[i*WIDTH +: WIDTH]});
      dv[i] = {{(D3-WIDTH-1){df[WIDTH]}}, df};
    end
    rv = wht(dv);
  end

  always_comb begin
    cv = '0;
    mag = '0;
    colsum = '0;
    for (int i = 0; i < N; i++) begin
      cv[i] = buf_q[i][col_q];
    end
    ch = wht(cv);
    for (int i = 0; i < N; i++) begin
      mag = ch[i][D3-1] ? (~ch[i] + D3'(1)) : ch[i];
      colsum = colsum + {{(OUT_W-D3){1'b0}}, mag};
    end
    total = acc_q + colsum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (xfer && last_row) state_d = VERT;
      VERT:    if (last_col) state_d = DONE;
      DONE:    if (out_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = state_q == LOAD;
    out_valid = state_q == DONE;
    busy      = (state_q != LOAD) || (row_q != '0);
  end

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    acc_d  = acc_q;
    satd_d = satd_q;
    if (xfer) row_d = row_q + LG'(1);
    case (state_q)
      LOAD: begin
        if (xfer && last_row) begin
          acc_d = '0;
          col_d = '0;
        end
      end
      VERT: begin
        acc_d = total;
        col_d = col_q + LG'(1);
        if (last_col) satd_d = (total + OUT_W'(RND)) >> SH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      acc_q  <= '0;
      satd_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      acc_q  <= acc_d;
      satd_q <= satd_d;
    end
  end

  // Every row is rewritten before VERT reads it, so no reset here
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        buf_q[row_q][i] <= rv[i];
      end
    end
  end

  assign satd = satd_q;

endmodule
